// File: rtl/parity_pkg.sv
// Shared types and helpers for the UART parity engine.
// Holds the parity mode and RX FSM encodings, the legal frame length
// limits and the mode-selection function used by both TX and RX paths.
package parity_pkg;

   typedef enum logic [1:0] {
      EVEN  = 2'b00,
      ODD   = 2'b01,
      MARK  = 2'b10,
      SPACE = 2'b11
   } parity_mode_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ACCUM    = 2'b01,
      WAIT_PAR = 2'b10
   } rx_state_e;

   localparam int MIN_LEN   = 5;
   localparam int MAX_WIDTH = 9;

   // Turn the XOR of the used data bits into the parity bit for a mode.
   function automatic logic apply_mode(input logic xor_bit, input parity_mode_e mode);
      logic result;
      case (mode)
         EVEN:    result = xor_bit;
         ODD:     result = ~xor_bit;
         MARK:    result = 1'b1;
         default: result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational parity of the low 'len' bits of a word.
// Bits at or above 'len' are masked to zero before the XOR reduction,
// then the mode selects even/odd/mark/space.
module parity_reduce
   import parity_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [LEN_W-1:0] len,
   input  parity_mode_e     mode,
   output logic             par
);

   logic [WIDTH-1:0] masked;

   // Keep only bit positions below the configured frame length.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_mask
         assign masked[gi] = data[gi] & (len > LEN_W'(gi));
      end
   endgenerate

   assign par = apply_mode(^masked, mode);

endmodule

// File: rtl/parity_engine.sv
// Parametrised UART parity engine: TX parity generation and RX parity check.
// TX: a word is shadowed on Data_Valid & ~Busy and its parity is registered
// one cycle later. RX: data bits are accumulated serially by a small FSM and
// the received parity bit is checked against the frame's expected parity.
// Optional build macro PARITY_ERR_CNT_EN adds a saturating parity error
// counter; without it err_count is constant zero and err_clr is unused.
module parity_engine
   import parity_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = $clog2(WIDTH + 1),
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             parity_enable,
   input  logic [1:0]       parity_mode,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             Data_Valid,
   input  logic             Busy,
   input  logic [WIDTH-1:0] DATA,
   output logic             parity,
   output logic             parity_ready,
   input  logic             rx_bit_valid,
   input  logic             rx_bit,
   input  logic             rx_par_valid,
   input  logic             rx_par_bit,
   input  logic             rx_abort,
   output logic             par_err_valid,
   output logic             par_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_count
);

   // ------------------------------------------------------------------
   // TX path
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] data_sh_reg;
   parity_mode_e     mode_sh_reg;
   logic [LEN_W-1:0] len_sh_reg;
   logic             cap_reg;
   logic             par_calc;
   logic             parity_reg;
   logic             parity_ready_reg;

   // Shadow the word and its configuration whenever the serializer is free.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_sh_reg <= '0;
         mode_sh_reg <= EVEN;
         len_sh_reg  <= '0;
         cap_reg     <= 1'b0;
      end else begin
         cap_reg <= Data_Valid & ~Busy;
         if (Data_Valid && !Busy) begin
            data_sh_reg <= DATA;
            mode_sh_reg <= parity_mode_e'(parity_mode);
            len_sh_reg  <= cfg_len;
         end
      end
   end

   parity_reduce #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) u_reduce (
      .data (data_sh_reg),
      .len  (len_sh_reg),
      .mode (mode_sh_reg),
      .par  (par_calc)
   );

   // Register the parity of the shadowed word on the cycle after capture.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         parity_reg       <= 1'b0;
         parity_ready_reg <= 1'b0;
      end else begin
         parity_ready_reg <= cap_reg & parity_enable;
         if (cap_reg && parity_enable) begin
            parity_reg <= par_calc;
         end
      end
   end

   assign parity       = parity_reg;
   assign parity_ready = parity_ready_reg;

   // ------------------------------------------------------------------
   // RX path
   // ------------------------------------------------------------------
   rx_state_e        state_reg, state_next;
   logic             acc_reg, acc_next;
   logic [LEN_W-1:0] cnt_reg, cnt_next;
   parity_mode_e     mode_rx_reg, mode_rx_next;
   logic [LEN_W-1:0] len_rx_reg, len_rx_next;
   logic             par_err_valid_reg, par_err_valid_next;
   logic             par_err_reg, par_err_next;
   logic [LEN_W-1:0] cnt_inc;

   assign cnt_inc = cnt_reg + LEN_W'(1);

   // RX state and frame registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg         <= IDLE;
         acc_reg           <= 1'b0;
         cnt_reg           <= '0;
         mode_rx_reg       <= EVEN;
         len_rx_reg        <= '0;
         par_err_valid_reg <= 1'b0;
         par_err_reg       <= 1'b0;
      end else begin
         state_reg         <= state_next;
         acc_reg           <= acc_next;
         cnt_reg           <= cnt_next;
         mode_rx_reg       <= mode_rx_next;
         len_rx_reg        <= len_rx_next;
         par_err_valid_reg <= par_err_valid_next;
         par_err_reg       <= par_err_next;
      end
   end

   // RX next-state: abort beats everything; config is frozen at frame start.
   always_comb begin
      state_next         = state_reg;
      acc_next           = acc_reg;
      cnt_next           = cnt_reg;
      mode_rx_next       = mode_rx_reg;
      len_rx_next        = len_rx_reg;
      par_err_valid_next = 1'b0;
      par_err_next       = par_err_reg;

      if (rx_abort) begin
         state_next = IDLE;
         acc_next   = 1'b0;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (rx_bit_valid && parity_enable) begin
                  state_next   = ACCUM;
                  mode_rx_next = parity_mode_e'(parity_mode);
                  len_rx_next  = cfg_len;
                  acc_next     = rx_bit;
                  cnt_next     = LEN_W'(1);
               end
            end
            ACCUM: begin
               if (rx_bit_valid) begin
                  acc_next = acc_reg ^ rx_bit;
                  cnt_next = cnt_inc;
                  // A parity strobe in the completing cycle is deliberately dropped.
                  if (cnt_inc >= len_rx_reg) begin
                     state_next = WAIT_PAR;
                  end
               end
            end
            WAIT_PAR: begin
               if (rx_par_valid) begin
                  state_next         = IDLE;
                  par_err_valid_next = 1'b1;
                  par_err_next       = apply_mode(acc_reg, mode_rx_reg) ^ rx_par_bit;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign par_err_valid = par_err_valid_reg;
   assign par_err       = par_err_reg;

   // ------------------------------------------------------------------
   // Error counter
   // ------------------------------------------------------------------
`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_count_reg;

   // Saturating error count; a clear in the same cycle as an error wins.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         err_count_reg <= '0;
      end else if (err_clr) begin
         err_count_reg <= '0;
      end else if (par_err_valid_reg && par_err_reg && (err_count_reg != {CNT_W{1'b1}})) begin
         err_count_reg <= err_count_reg + CNT_W'(1);
      end
   end

   assign err_count = err_count_reg;
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign err_count      = '0;
`endif

endmodule
